// File: rtl/quad_frame_stats.sv
// Per-frame statistics over (x, y) sample pairs: min/max of y with their x,
// the running sum of y, and the number of sign changes between consecutive y.
module quad_frame_stats #(
  parameter int W         = 10,
  parameter int FRAME_LEN = 128,
  parameter int CNT_W     = 8,
  parameter int SUM_W     = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     x_in,
  input  logic signed [W-1:0]     y_in,
  output logic signed [W-1:0]     min_y,
  output logic signed [W-1:0]     min_x,
  output logic signed [W-1:0]     max_y,
  output logic signed [W-1:0]     max_x,
  output logic signed [SUM_W-1:0] sum_y,
  output logic [CNT_W-1:0]        zc_count,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    first_q;
  logic                    prev_neg_q;
  logic signed [W-1:0]     min_y_q, min_x_q, max_y_q, max_x_q;
  logic signed [SUM_W-1:0] sum_y_q;
  logic [CNT_W-1:0]        zc_q;
  logic                    busy_q, done_q;

  logic                    frame_full;
  logic                    handshake;
  logic                    y_neg;
  logic signed [SUM_W-1:0] y_ext;

  // Once the last sample is taken, the block stops accepting for the one
  // cycle it stays in ACCUM before moving to DONE.
  assign frame_full = (cnt_q == LAST_CNT);
  assign in_ready   = (state_q == S_ACCUM) && !frame_full;
  assign handshake  = in_valid && in_ready;
  assign y_neg      = y_in[W-1];
  assign y_ext      = {{(SUM_W-W){y_in[W-1]}}, y_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      prev_neg_q <= 1'b0;
      min_y_q    <= '0;
      min_x_q    <= '0;
      max_y_q    <= '0;
      max_x_q    <= '0;
      sum_y_q    <= '0;
      zc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_ACCUM;
            cnt_q   <= '0;
            first_q <= 1'b1;
            min_y_q <= '0;
            min_x_q <= '0;
            max_y_q <= '0;
            max_x_q <= '0;
            sum_y_q <= '0;
            zc_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (frame_full) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (handshake) begin
            cnt_q      <= cnt_q + 1'b1;
            first_q    <= 1'b0;
            prev_neg_q <= y_neg;
            if (first_q) begin
              min_y_q <= y_in;
              min_x_q <= x_in;
              max_y_q <= y_in;
              max_x_q <= x_in;
              sum_y_q <= y_ext;
              zc_q    <= '0;
            end else begin
              // Strict compares keep the earliest x on ties.
              if (y_in < min_y_q) begin
                min_y_q <= y_in;
                min_x_q <= x_in;
              end
              if (y_in > max_y_q) begin
                max_y_q <= y_in;
                max_x_q <= x_in;
              end
              sum_y_q <= sum_y_q + y_ext;
              if (y_neg != prev_neg_q) zc_q <= zc_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign min_y    = min_y_q;
  assign min_x    = min_x_q;
  assign max_y    = max_y_q;
  assign max_x    = max_x_q;
  assign sum_y    = sum_y_q;
  assign zc_count = zc_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
